branch_pred_btb: RTL and testbench
==================================

# branch_pred_btb

Parametrised branch target buffer with per-entry saturating direction counters, the successor to the fixed 256-entry, direct-mapped, 2-bit predictor. It is looked up combinationally in IF with the fetch PC and supplies the predicted next PC and counter state to carry down the pipeline. It is updated at the clock edge from the branch-resolution stage. It generalises index width, associativity (1 or 2 ways, LRU replacement) and counter width, and adds a single-cycle flush.

## Interface
- IDX_W, 8: index bits; SETS = 2^IDX_W; TAG_W = 30 - IDX_W
- WAYS, 2: associativity; legal values 1 or 2
- CNT_W, 2: direction counter width; legal range 1..4
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- lkup_pc  in  32  fetch PC
- pred_hit  out  1  tag match in a valid way
- pred_taken  out  1  pred_hit && counter MSB == 1
- pred_npc  out  32  target if pred_taken, else lkup_pc + 4
- pred_state  out  CNT_W  counter of the hit way; 0 on miss
- upd_en  in  1  resolved branch this cycle
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual branch target
- flush  in  1  invalidate all entries

## Operation
- Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], cnt[CNT_W-1:0]. Each set has one LRU bit when WAYS=2; it records the way *not* most recently written.
- Lookup is purely combinational from the stored state. On a multi-way match, which can only arise from a bug, the lowest way wins.
- Update on a hit, when upd_en=1 and the tag matches a valid way:
  - If upd_taken: cnt = min(cnt+1, 2^CNT_W-1) and target <= upd_target.
  - Otherwise: cnt = max(cnt-1, 0) and target is unchanged.
  - LRU points to the other way.
- Update on a miss with upd_taken=1: allocate the lowest invalid way, or the LRU way if none is invalid.
  - Write valid=1, the tag and upd_target.
  - cnt = 2^(CNT_W-1), i.e. weakly taken.
  - LRU points to the other way.
- Update on a miss with upd_taken=0: no state change.
- Lookups never touch LRU.
- WAYS=1: no LRU storage; allocation always overwrites way 0.
- flush=1: every valid bit clears at the edge. Tags, targets and counters are left stale.
- Reset (nRST low): all valid bits, counters and LRU bits clear immediately. Tags and targets need not reset.

## Timing
- Lookup latency is 0 cycles: outputs are combinational from lkup_pc and the current state.
- Update latency is 1 cycle: an update at edge N is visible to lookups after edge N.
- No bypass: a same-cycle lookup of the PC being updated returns the pre-update contents.
- flush and upd_en in the same cycle: flush wins and the update is dropped.
- During or immediately after reset, before any update: pred_hit=0, pred_taken=0, pred_state=0, pred_npc=lkup_pc+4.
- nRST asserted mid-operation forces the miss outputs asynchronously, without waiting for a clock edge.
- pred_npc arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).

## Test plan
All scenarios use IDX_W=8, WAYS=2, CNT_W=2.
- Reset, then lkup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_state=0, pred_npc=0x44.
- Update 0x40 taken with target 0x100, then lookup 0x40 -> hit=1, state=2'b10, taken=1, npc=0x100.
  - Three more taken updates -> state=2'b11 and stays there.
  - Four not-taken updates -> 10, 01, 00, 00; taken=0 from 01 down, hit stays 1, npc=0x44.
- Not-taken update of miss PC 0x80 -> lookup 0x80 still hit=0.
- Aliasing on index 0x10:
  - Allocate 0x040 (target 0x200), then 0x440 (target 0x300) -> both hit with their own targets.
  - Taken update of 0x840 (target 0x400) evicts 0x040 -> 0x040 misses; 0x440 and 0x840 hit.
- flush together with a taken update of 0x900 -> next cycle, 0x440, 0x840 and 0x900 all miss.
- Same-cycle update and lookup of 0xC0, with an async nRST pulse mid-cycle:
  - Same cycle: the lookup shows miss. Next cycle: hit.
  - nRST pulse low between edges -> pred_hit falls to 0 before the next CLK edge.

Source files
------------

// File: rtl/branch_pred_btb.sv
// rtl/branch_pred_btb.sv - set-associative branch target buffer with saturating direction counters
module branch_pred_btb #(
  parameter int IDX_W = 8,
  parameter int WAYS  = 2,
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      lkup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_npc,
  output logic [CNT_W-1:0] pred_state,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             flush
);

  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(2 ** (CNT_W - 1));

  // Storage. Valid bits and counters are reset; tags and targets are plain RAM.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [CNT_W-1:0] cnt_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      tgt_q   [SETS][WAYS];

  // Byte-offset bits of both PCs carry no information for a word-aligned BTB.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lkup_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [CNT_W-1:0] lk_cnt;
  logic [31:0]      lk_tgt;

  assign lk_idx = lkup_pc[IDX_W+1:2];
  assign lk_tag = lkup_pc[31:IDX_W+2];

  // Tag compare across ways; scanning high-to-low lets the lowest matching way win.
  always_comb begin
    lk_hit = 1'b0;
    lk_cnt = '0;
    lk_tgt = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_cnt = cnt_q[lk_idx][w];
        lk_tgt = tgt_q[lk_idx][w];
      end
    end
  end

  assign pred_hit   = lk_hit;
  assign pred_taken = lk_hit & lk_cnt[CNT_W-1];
  assign pred_state = lk_cnt;
  assign pred_npc   = pred_taken ? lk_tgt : (lkup_pc + 32'd4);

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_hit_way;
  logic             alloc_way;
  logic             victim_lru;
  logic             wr_way;
  logic             do_write;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] new_cnt;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  // Find the resolving branch's way and the allocation victim: lowest invalid way, else LRU.
  always_comb begin
    u_hit     = 1'b0;
    u_hit_way = 1'b0;
    alloc_way = victim_lru;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit     = 1'b1;
        u_hit_way = 1'(w);
      end
      if (!valid_q[u_idx][w]) begin
        alloc_way = 1'(w);
      end
    end
  end

  // A not-taken miss never allocates; flush always overrides an update.
  assign wr_way   = u_hit ? u_hit_way : alloc_way;
  assign do_write = upd_en && !flush && (u_hit || upd_taken);
  assign cur_cnt  = cnt_q[u_idx][wr_way];

  // Next counter value: weakly taken on allocation, saturating step on a hit.
  always_comb begin
    new_cnt = cur_cnt;
    if (!u_hit) begin
      new_cnt = CNT_WEAK;
    end else if (upd_taken) begin
      new_cnt = (cur_cnt == CNT_MAX) ? cur_cnt : (cur_cnt + CNT_ONE);
    end else begin
      new_cnt = (cur_cnt == '0) ? cur_cnt : (cur_cnt - CNT_ONE);
    end
  end

  // Valid bits and counters; reset clears them immediately, flush clears only valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          cnt_q[s][w] <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (do_write) begin
      valid_q[u_idx][wr_way] <= 1'b1;
      cnt_q[u_idx][wr_way]   <= new_cnt;
    end
  end

  // Tag and target RAM; the target only moves on a taken resolution.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      tag_q[u_idx][wr_way] <= u_tag;
      if (upd_taken) begin
        tgt_q[u_idx][wr_way] <= upd_target;
      end
    end
  end

  generate
    if (WAYS == 2) begin : g_lru
      logic lru_q [SETS];

      // LRU bit names the way that was not written most recently.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int s = 0; s < SETS; s++) begin
            lru_q[s] <= 1'b0;
          end
        end else if (do_write) begin
          lru_q[u_idx] <= ~wr_way;
        end
      end

      assign victim_lru = lru_q[u_idx];
    end else begin : g_no_lru
      assign victim_lru = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_branch_pred_btb.sv
// tb/tb_branch_pred_btb.sv - randomized self-checking bench for branch_pred_btb
module tb_branch_pred_btb;

  logic        CLK;
  logic        nRST;
  logic [31:0] lkup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic [1:0]  pred_state;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  branch_pred_btb #(.IDX_W(8), .WAYS(2), .CNT_W(2)) dut (
    .CLK(CLK), .nRST(nRST), .lkup_pc(lkup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc), .pred_state(pred_state),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: each set is a list of entries ordered oldest-written first, at most two long.
  typedef struct {
    logic [21:0] tag;
    logic [31:0] tgt;
    int          cnt;
  } ent_t;

  ent_t set_q [256][$];

  function automatic int model_find(input logic [31:0] pc);
    int s = int'(pc[9:2]);
    for (int i = 0; i < set_q[s].size(); i++)
      if (set_q[s][i].tag == pc[31:10]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 256; s++) set_q[s].delete();
  endtask

  task automatic model_update();
    int   s;
    int   i;
    ent_t e;
    if (!nRST) return;
    if (flush) begin
      model_clear();
      return;
    end
    if (!upd_en) return;
    s = int'(upd_pc[9:2]);
    i = model_find(upd_pc);
    if (i >= 0) begin
      e = set_q[s][i];
      if (upd_taken) begin
        e.cnt = (e.cnt + 1 > 3) ? 3 : e.cnt + 1;
        e.tgt = upd_target;
      end else begin
        e.cnt = (e.cnt - 1 < 0) ? 0 : e.cnt - 1;
      end
      set_q[s].delete(i);
      set_q[s].push_back(e);
    end else if (upd_taken) begin
      if (set_q[s].size() == 2) void'(set_q[s].pop_front());
      e.tag = upd_pc[31:10];
      e.tgt = upd_target;
      e.cnt = 2;
      set_q[s].push_back(e);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (pc %h, t=%0t)", tag, got, exp, lkup_pc, $time);
    end
  endtask

  task automatic model_compare();
    int   i = model_find(lkup_pc);
    int   s = int'(lkup_pc[9:2]);
    logic exp_taken;
    if (i < 0) begin
      check("hit", 32'(pred_hit), 32'd0);
      check("taken", 32'(pred_taken), 32'd0);
      check("state", 32'(pred_state), 32'd0);
      check("npc", pred_npc, lkup_pc + 32'd4);
    end else begin
      exp_taken = (set_q[s][i].cnt >= 2);
      check("hit", 32'(pred_hit), 32'd1);
      check("taken", 32'(pred_taken), 32'(exp_taken));
      check("state", 32'(pred_state), 32'(set_q[s][i].cnt));
      check("npc", pred_npc, exp_taken ? set_q[s][i].tgt : lkup_pc + 32'd4);
    end
  endtask

  // Drive one cycle's inputs away from the edge, then compare lookup against the model.
  task automatic drive(input logic [31:0] pc, input logic ue, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic fl);
    @(negedge CLK);
    lkup_pc    = pc;
    upd_en     = ue;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    flush      = fl;
    #1;
    model_compare();
  endtask

  task automatic commit();
    @(posedge CLK);
    model_update();
  endtask

  task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
    drive(upc, 1'b1, upc, ut, utgt, 1'b0);
    commit();
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic [1:0] es, input logic [31:0] en);
    drive(pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("d_hit", 32'(pred_hit), 32'(eh));
    check("d_state", 32'(pred_state), 32'(es));
    check("d_npc", pred_npc, en);
    commit();
  endtask

  initial begin
    logic [1:0] exp_nt [4];
    logic [31:0] rpc;
    logic [31:0] rupc;
    exp_nt = '{2'b10, 2'b01, 2'b00, 2'b00};

    nRST = 1'b0; lkup_pc = 32'h40; upd_en = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
    model_clear();
    #2;
    check("rst_hit", 32'(pred_hit), 32'd0);
    check("rst_taken", 32'(pred_taken), 32'd0);
    check("rst_state", 32'(pred_state), 32'd0);
    check("rst_npc", pred_npc, 32'h44);
    @(negedge CLK);
    nRST = 1'b1;

    look(32'h40, 1'b0, 2'b00, 32'h44);
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 2'b10, 32'h100);
    for (int k = 0; k < 3; k++) upd(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 2'b11, 32'h100);
    for (int k = 0; k < 4; k++) begin
      upd(32'h40, 1'b0, 32'h0);
      look(32'h40, 1'b1, exp_nt[k], exp_nt[k][1] ? 32'h100 : 32'h44);
    end

    upd(32'h80, 1'b0, 32'h999);
    look(32'h80, 1'b0, 2'b00, 32'h84);

    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    commit();
    upd(32'h040, 1'b1, 32'h200);
    upd(32'h440, 1'b1, 32'h300);
    look(32'h040, 1'b1, 2'b10, 32'h200);
    look(32'h440, 1'b1, 2'b10, 32'h300);
    upd(32'h840, 1'b1, 32'h400);
    look(32'h040, 1'b0, 2'b00, 32'h044);
    look(32'h440, 1'b1, 2'b10, 32'h300);
    look(32'h840, 1'b1, 2'b10, 32'h400);

    drive(32'h900, 1'b1, 32'h900, 1'b1, 32'h500, 1'b1);
    commit();
    look(32'h440, 1'b0, 2'b00, 32'h444);
    look(32'h840, 1'b0, 2'b00, 32'h844);
    look(32'h900, 1'b0, 2'b00, 32'h904);

    drive(32'hC0, 1'b1, 32'hC0, 1'b1, 32'h600, 1'b0);
    check("bypass_hit", 32'(pred_hit), 32'd0);
    commit();
    drive(32'hC0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("post_upd_hit", 32'(pred_hit), 32'd1);
    nRST = 1'b0;
    #1;
    check("async_hit", 32'(pred_hit), 32'd0);
    check("async_state", 32'(pred_state), 32'd0);
    check("async_npc", pred_npc, 32'hC4);
    model_clear();
    #1;
    nRST = 1'b1;
    commit();
    look(32'hC0, 1'b0, 2'b00, 32'hC4);

    look(32'hFFFF_FFFC, 1'b0, 2'b00, 32'h0000_0000);
    upd(32'hFFFF_FFFC, 1'b1, 32'h1234);
    look(32'hFFFF_FFFE, 1'b1, 2'b10, 32'h1234);

    for (int k = 0; k < 3000; k++) begin
      rpc  = ($urandom_range(0, 3) << 10) | ($urandom_range(16, 18) << 2) | $urandom_range(0, 3);
      rupc = ($urandom_range(0, 3) << 10) | ($urandom_range(16, 18) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) rupc = rpc;
      drive(rpc, ($urandom_range(0, 9) < 6), rupc, ($urandom_range(0, 9) < 6),
            $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 99) < 3));
      commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
